// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies LOCK, releases the downstream reset.
// Optional lock-loss event counter output enabled by `define PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 27,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pll_lock,
    input  logic                               force_relock,
    output logic                               pll_reset,
    output logic                               sys_rst_n,
    output logic                               locked,
    output logic                               fail,
`ifdef PLL_LOCK_LOSS_COUNT_EN
    output logic [7:0]                         lock_loss_cnt,
`endif
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int RCW = $clog2(PLL_RST_CYCLES + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int RTW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic           lock_meta_q, lock_s_q;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d, to_inc;
    logic [SW-1:0]  stb_cnt_q, stb_cnt_d, stb_inc;
    logic [RTW-1:0] retry_q, retry_d;
    logic           pll_reset_q, sys_rst_n_q, locked_q, fail_q;
    logic           timeout;

    // pll_lock comes from the PLL's own domain; resynchronise before any use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign to_inc  = to_cnt_q + TW'(1);
    assign stb_inc = stb_cnt_q + SW'(1);
    assign timeout = (to_inc == TW'(LOCK_TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;

        if (force_relock) begin
            state_d   = S_RESET_PLL;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (rst_cnt_q == RCW'(PLL_RST_CYCLES - 1)) begin
                        state_d   = S_WAIT_LOCK;
                        rst_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RCW'(1);
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    to_cnt_d = to_inc;
                    if (state_q == S_STABLE && lock_s_q && stb_inc == SW'(LOCK_STABLE_CYCLES)) begin
                        // Stable completion wins over a coincident timeout.
                        state_d   = S_RUN;
                        stb_cnt_d = '0;
                    end else if (timeout) begin
                        to_cnt_d  = '0;
                        stb_cnt_d = '0;
                        rst_cnt_d = '0;
                        if (retry_q < RTW'(MAX_RETRIES)) begin
                            retry_d = retry_q + RTW'(1);
                            state_d = S_RESET_PLL;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else if (state_q == S_WAIT_LOCK) begin
                        if (lock_s_q) begin
                            state_d   = S_STABLE;
                            stb_cnt_d = '0;
                        end
                    end else if (lock_s_q) begin
                        stb_cnt_d = stb_inc;
                    end else begin
                        // Timeout keeps running so a flickering lock still ends in a retry.
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d   = S_WAIT_LOCK;
                        to_cnt_d  = '0;
                        stb_cnt_d = '0;
                        retry_d   = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d   = S_RESET_PLL;
                    rst_cnt_d = '0;
                    to_cnt_d  = '0;
                    stb_cnt_d = '0;
                    retry_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == S_RESET_PLL);
            sys_rst_n_q <= (state_d == S_RUN);
            locked_q    <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == S_RUN && state_d == S_WAIT_LOCK && loss_q != 8'hFF)
            loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: clean lock, lock loss, flicker, timeout/FAIL,
// recovery and mid-sequence reset, with hand-derived cycle expectations.
module tb_pll_lock_sequencer;

    logic       clk, rst_n, pll_lock, force_relock;
    logic       pll_reset, sys_rst_n, locked, fail;
    logic [1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int hi, shi;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(50),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .sys_rst_n    (sys_rst_n),
        .locked       (locked),
        .fail         (fail),
`ifdef PLL_LOCK_LOSS_COUNT_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .retry_cnt    (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pll_lock = 1'b0; force_relock = 1'b0;
        step(2);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("rst_locked",    32'(locked),    0);
        chk("rst_fail",      32'(fail),      0);
        chk("rst_retry",     32'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("rst_loss",      32'(lock_loss_cnt), 0);
`endif

        // Clean lock: 4-cycle pll_reset, lock raised 10 cycles after release.
        rst_n = 1'b1;
        hi = 32'(pll_reset);
        for (int i = 1; i <= 6; i++) begin
            step(1);
            hi += 32'(pll_reset);
        end
        chk("clean_pll_rst_width", 32'(hi), 4);
        step(4);
        pll_lock = 1'b1;
        // 2 sync edges + 1 to STABLE + 8 stable edges = release 11 edges later.
        step(10);
        chk("clean_pre_release", 32'(sys_rst_n), 0);
        step(1);
        chk("clean_sys_rst_n", 32'(sys_rst_n), 1);
        chk("clean_locked",    32'(locked),    1);
        chk("clean_retry",     32'(retry_cnt), 0);

        // Lock loss in RUN: release drops 3 edges after pll_lock falls, no PLL reset.
        pll_lock = 1'b0;
        step(2);
        chk("loss_still_run", 32'(sys_rst_n), 1);
        step(1);
        chk("loss_sys_rst_n", 32'(sys_rst_n), 0);
        chk("loss_locked",    32'(locked),    0);
        chk("loss_pll_reset", 32'(pll_reset), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("loss_cnt", 32'(lock_loss_cnt), 1);
`endif

        // Relock with a 1-cycle dropout landing at stable count 5.
        pll_lock = 1'b1;
        step(6);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        hi = 0;
        for (int i = 8; i <= 18; i++) begin
            step(1);
            hi += 32'(pll_reset);
            if (i == 11) chk("flick_no_early_release", 32'(sys_rst_n), 0);
            if (i == 17) chk("flick_pre_release",      32'(sys_rst_n), 0);
            if (i == 18) begin
                chk("flick_release", 32'(sys_rst_n), 1);
                chk("flick_retry",   32'(retry_cnt), 0);
            end
        end
        chk("flick_no_pll_reset", 32'(hi), 0);

        // Timeout path: force_relock with no lock -> 3 pulses, retries 1,2, then FAIL.
        force_relock = 1'b1;
        pll_lock = 1'b0;
        hi = 0; shi = 0;
        for (int i = 1; i <= 170; i++) begin
            step(1);
            if (i == 1) begin
                force_relock = 1'b0;
                chk("to_force_sys_rst_n", 32'(sys_rst_n), 0);
                chk("to_force_pll_reset", 32'(pll_reset), 1);
            end
            hi  += 32'(pll_reset);
            shi += 32'(sys_rst_n);
            if (i == 54)  chk("to_before_retry1", 32'(pll_reset), 0);
            if (i == 56)  chk("to_retry1", 32'(retry_cnt), 1);
            if (i == 110) chk("to_retry2", 32'(retry_cnt), 2);
            if (i == 162) chk("to_not_yet_fail", 32'(fail), 0);
            if (i == 163) begin
                chk("to_fail",       32'(fail),      1);
                chk("to_fail_retry", 32'(retry_cnt), 2);
            end
        end
        chk("to_pulse_cycles", 32'(hi), 12);
        chk("to_sys_rst_n_never", 32'(shi), 0);

        // FAIL is sticky even once the PLL locks.
        pll_lock = 1'b1;
        step(5);
        chk("fail_sticky",    32'(fail),      1);
        chk("fail_locked",    32'(locked),    0);
        chk("fail_pll_reset", 32'(pll_reset), 0);

        // Recovery via force_relock.
        force_relock = 1'b1;
        hi = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            hi += 32'(pll_reset);
            if (i == 1) begin
                force_relock = 1'b0;
                chk("rec_fail_clr",  32'(fail),      0);
                chk("rec_retry_clr", 32'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
                chk("rec_loss_kept", 32'(lock_loss_cnt), 1);
`endif
            end
            if (i == 13) chk("rec_pre_release", 32'(sys_rst_n), 0);
            if (i == 14) begin
                chk("rec_release", 32'(sys_rst_n), 1);
                chk("rec_locked",  32'(locked),    1);
            end
        end
        chk("rec_pulse_cycles", 32'(hi), 4);

        // Async reset at stable count 4.
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        step(9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pll_reset", 32'(pll_reset), 1);
        chk("mid_rst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("mid_rst_locked",    32'(locked),    0);
        chk("mid_rst_retry",     32'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("mid_rst_loss", 32'(lock_loss_cnt), 0);
`endif
        step(1);
        rst_n = 1'b1;
        hi = 32'(pll_reset);
        for (int i = 1; i <= 13; i++) begin
            step(1);
            hi += 32'(pll_reset);
            if (i == 12) chk("mid_pre_release", 32'(sys_rst_n), 0);
            if (i == 13) chk("mid_release",     32'(sys_rst_n), 1);
        end
        chk("mid_pulse_cycles", 32'(hi), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
